// File: rtl/montgomery_mult_serial.sv
`default_nettype none
// ============================================================================
//  Module   : montgomery_mult_serial
//  Purpose  : Bit-serial Montgomery multiplier, R = A*B*2^-WIDTH mod N.
//  Revision : 1.0
// ============================================================================
module montgomery_mult_serial #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rstb,
    input  logic             ena,
    input  logic             start,
    input  logic [WIDTH-1:0] A_i,
    input  logic [WIDTH-1:0] B_i,
    input  logic [WIDTH-1:0] N_i,
    output logic [WIDTH-1:0] R_o,
    output logic             busy_o,
    output logic             done_o
);

    localparam int CW = $clog2(WIDTH);
    localparam int AW = WIDTH + 2;
    localparam logic [CW-1:0] c_LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_RUN     = 2'd1,
        S_CORRECT = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_next;

    logic [AW-1:0]    r_acc;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_n;

    logic [AW-1:0]    w_acc_next;
    logic [CW-1:0]    w_cnt_next;
    logic [WIDTH-1:0] w_a_next;
    logic [WIDTH-1:0] w_b_next;
    logic [WIDTH-1:0] w_n_next;
    logic [WIDTH-1:0] w_r_next;
    logic             w_busy_next;
    logic             w_done_next;

    // One reduction step: add b if the scanned bit is set, make the sum even
    // with n, then halve. Two guard bits keep the sum below 4N.
    logic [AW-1:0]    w_t;
    logic [AW-1:0]    w_tn;
    logic [AW-1:0]    w_step;
    logic [WIDTH-1:0] w_corr;

    assign w_t    = r_acc + (r_a[r_cnt] ? {2'b00, r_b} : '0);
    assign w_tn   = w_t + (w_t[0] ? {2'b00, r_n} : '0);
    assign w_step = w_tn >> 1;
    assign w_corr = (r_acc >= {2'b00, r_n}) ? (r_acc[WIDTH-1:0] - r_n)
                                            : r_acc[WIDTH-1:0];

    always_ff @(posedge clk) begin
        if (!rstb) begin
            r_state <= S_IDLE;
        end else if (ena) begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_acc_next   = r_acc;
        w_cnt_next   = r_cnt;
        w_a_next     = r_a;
        w_b_next     = r_b;
        w_n_next     = r_n;
        w_r_next     = R_o;
        w_busy_next  = busy_o;
        w_done_next  = done_o;
        case (r_state)
            S_IDLE: begin
                w_done_next = 1'b0;
                if (start) begin
                    w_a_next     = A_i;
                    w_b_next     = B_i;
                    w_n_next     = N_i;
                    w_acc_next   = '0;
                    w_cnt_next   = '0;
                    w_busy_next  = 1'b1;
                    w_state_next = S_RUN;
                end
            end
            S_RUN: begin
                w_acc_next = w_step;
                w_cnt_next = r_cnt + CW'(1);
                if (r_cnt == c_LAST) begin
                    w_state_next = S_CORRECT;
                end
            end
            S_CORRECT: begin
                w_r_next     = w_corr;
                w_done_next  = 1'b1;
                w_busy_next  = 1'b0;
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstb) begin
            r_acc  <= '0;
            r_cnt  <= '0;
            r_a    <= '0;
            r_b    <= '0;
            r_n    <= '0;
            R_o    <= '0;
            busy_o <= 1'b0;
            done_o <= 1'b0;
        end else if (ena) begin
            r_acc  <= w_acc_next;
            r_cnt  <= w_cnt_next;
            r_a    <= w_a_next;
            r_b    <= w_b_next;
            r_n    <= w_n_next;
            R_o    <= w_r_next;
            busy_o <= w_busy_next;
            done_o <= w_done_next;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_montgomery_mult_serial.sv
`default_nettype none
// ============================================================================
//  Module   : tb_montgomery_mult_serial
//  Purpose  : Directed and back-to-back checks of the serial Montgomery unit.
//  Revision : 1.0
// ============================================================================
module tb_montgomery_mult_serial;

    localparam int W = 8;

    logic         clk   = 1'b0;
    logic         rstb  = 1'b0;
    logic         ena   = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] a_in  = '0;
    logic [W-1:0] b_in  = '0;
    logic [W-1:0] n_in  = 8'd13;
    logic [W-1:0] r_out;
    logic         busy;
    logic         done;

    int checks = 0;
    int errors = 0;
    int exp_q[$];
    int exp_r  = 0;
    bit prev_done = 1'b0;

    montgomery_mult_serial #(.WIDTH(W)) u_dut (
        .clk    (clk),
        .rstb   (rstb),
        .ena    (ena),
        .start  (start),
        .A_i    (a_in),
        .B_i    (b_in),
        .N_i    (n_in),
        .R_o    (r_out),
        .busy_o (busy),
        .done_o (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, req);
        end
    endtask

    // Golden result: the x in [0,N) with x*2^W == A*B (mod N).
    function automatic int mont(input int a, input int b, input int n);
        int r;
        r = (a * b) % n;
        for (int x = 0; x < n; x++) begin
            if (((x << W) % n) == r) return x;
        end
        return -1;
    endfunction

    // Compare process: R_o must always equal the last completed result.
    initial begin
        forever begin
            @(negedge clk);
            if (!rstb) begin
                exp_r = 0;
                exp_q.delete();
            end else begin
                if (done && !prev_done) begin
                    chk("done_expected", {31'b0, exp_q.size() > 0}, 1);
                    if (exp_q.size() > 0) exp_r = exp_q.pop_front();
                    chk("busy_at_done", {31'b0, busy}, 0);
                end
                chk("R_o_track", {24'b0, r_out}, exp_r);
            end
            prev_done = done;
        end
    end

    task automatic run_op(input int a, input int b, input int n, input int req_r,
                          input int req_lat, input int gap_at, input int gap_len,
                          input int mid_start_at);
        int lat;
        int busy_cnt;
        a_in  = W'(a);
        b_in  = W'(b);
        n_in  = W'(n);
        start = 1'b1;
        exp_q.push_back(mont(a, b, n));
        @(posedge clk); #1;
        start    = 1'b0;
        lat      = 0;
        busy_cnt = 0;
        while (!done && lat < 40) begin
            if (busy) busy_cnt++;
            ena   = !(lat >= gap_at && lat < gap_at + gap_len);
            start = (lat == mid_start_at);
            @(posedge clk); #1;
            lat++;
        end
        ena   = 1'b1;
        start = 1'b0;
        chk("latency", lat, req_lat);
        chk("busy_cycles", busy_cnt, req_lat);
        chk("result", {24'b0, r_out}, req_r);
        chk("busy_after_done", {31'b0, busy}, 0);
    endtask

    initial begin
        int na[8];
        int aa[8];
        int ba[8];
        int lat;

        chk("model_5_7_13", mont(5, 7, 13), 1);
        chk("model_1_1_13", mont(1, 1, 13), 3);
        chk("model_0_12_13", mont(0, 12, 13), 0);
        chk("model_254_254_255", mont(254, 254, 255), 1);

        repeat (2) @(posedge clk);
        #1 rstb = 1'b1;
        chk("reset_R", {24'b0, r_out}, 0);
        chk("reset_busy", {31'b0, busy}, 0);
        chk("reset_done", {31'b0, done}, 0);
        @(posedge clk); #1;

        // Basic, identity-ish and top-carry cases.
        run_op(5, 7, 13, 1, 9, -1, 0, -1);
        run_op(1, 1, 13, 3, 9, -1, 0, -1);
        run_op(0, 12, 13, 0, 9, -1, 0, -1);
        run_op(254, 254, 255, 1, 9, -1, 0, -1);

        // Stall in RUN plus an ignored start pulse.
        run_op(5, 7, 13, 1, 12, 3, 3, 2);
        repeat (12) @(posedge clk);
        #1 chk("stall_no_extra_done", {31'b0, done}, 0);
        chk("stall_R_hold", {24'b0, r_out}, 1);

        // Reset in the middle of RUN aborts with no done.
        a_in  = 8'd3;
        b_in  = 8'd4;
        n_in  = 8'd13;
        start = 1'b1;
        exp_q.push_back(mont(3, 4, 13));
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1 rstb = 1'b0;
        @(posedge clk); #1;
        rstb = 1'b1;
        chk("midrst_R", {24'b0, r_out}, 0);
        chk("midrst_busy", {31'b0, busy}, 0);
        chk("midrst_done", {31'b0, done}, 0);
        repeat (15) @(posedge clk);
        #1 chk("midrst_no_done", {31'b0, done}, 0);

        // Back-to-back: start held high across each done pulse.
        for (int k = 0; k < 8; k++) begin
            na[k] = 2 * $urandom_range(1, 127) + 1;
            aa[k] = $urandom_range(0, na[k] - 1);
            ba[k] = $urandom_range(0, na[k] - 1);
        end
        na[0] = 13; aa[0] = 12; ba[0] = 12;
        a_in  = W'(aa[0]);
        b_in  = W'(ba[0]);
        n_in  = W'(na[0]);
        start = 1'b1;
        exp_q.push_back(mont(aa[0], ba[0], na[0]));
        @(posedge clk); #1;
        for (int k = 0; k < 8; k++) begin
            lat = 0;
            do begin
                @(posedge clk); #1;
                lat++;
            end while (!done && lat < 40);
            chk("b2b_latency", lat, (k == 0) ? 9 : 10);
            chk("b2b_result", {24'b0, r_out}, mont(aa[k], ba[k], na[k]));
            if (k < 7) begin
                a_in = W'(aa[k+1]);
                b_in = W'(ba[k+1]);
                n_in = W'(na[k+1]);
                exp_q.push_back(mont(aa[k+1], ba[k+1], na[k+1]));
            end else begin
                start = 1'b0;
            end
        end

        repeat (5) @(posedge clk);
        #1 chk("queue_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
